// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba multiplier: FSM state
// encoding, fixed accept-to-result latency and the WIDTH legality helper.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_Z0 = 3'd1,
    MUL_Z2 = 3'd2,
    MUL_Z1 = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Rising edges from operand accept to out_valid rising.
  localparam int LATENCY = 4;

  // WIDTH must be a power of two between 8 and 64 so the operand halves are equal.
  function automatic bit width_ok(input int w);
    return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/karatsuba_core_mul.sv
// Combinational unsigned N x N multiplier shared by the three partial
// products (al*bl, ah*bh and the (H+1)-bit sum product).
module karatsuba_core_mul #(
  parameter int N = 17
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] prod
);

  // Both operands zero-extended so the full 2N-bit product is kept.
  assign prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};

endmodule

// File: rtl/karatsuba_seq_mult.sv
// Sequential Karatsuba multiplier: one shared (H+1)x(H+1) multiplier computes
// z0, z2 and z1 in three consecutive cycles, then the product is assembled.
// Optional feature: define KARATSUBA_APPROX_EN to zero the low APPROX_BITS
// product bits (z0 low bits are not added); latency and handshake unchanged.
module karatsuba_seq_mult
  import karatsuba_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int APPROX_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int MW = H + 1;
  localparam int PW = 2 * WIDTH;

  generate
    if (!width_ok(WIDTH) || (APPROX_BITS < 1) || (APPROX_BITS > WIDTH)) begin : g_bad_cfg
      $error("karatsuba_seq_mult: illegal WIDTH or APPROX_BITS");
    end
  endgenerate

  // Handshake: an operand pair transfers on a rising edge where
  // in_valid && in_ready; a product transfers on a rising edge where
  // out_valid && out_ready. A valid source holds its data until transfer.
  // DONE first assembles p; p is then held until the consumer takes it.
  // in_ready is high in DONE whenever out_ready is high, so the next pair can
  // be accepted on the same edge that loads or hands off the current result.

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH-1:0]   z0, z2;
  logic [WIDTH+1:0]   z1;
  logic               loaded;
  logic               accept;

  logic [H-1:0]       ah, al, bh, bl;
  logic [MW-1:0]      sum_a, sum_b;
  logic [MW-1:0]      mx, my;
  logic [2*MW-1:0]    mprod;
  logic [2*MW-1:0]    z1_full;
  logic [PW-1:0]      z0_term;
  logic [PW-1:0]      p_asm;

  assign ah    = a_r[WIDTH-1:H];
  assign al    = a_r[H-1:0];
  assign bh    = b_r[WIDTH-1:H];
  assign bl    = b_r[H-1:0];
  assign sum_a = {1'b0, ah} + {1'b0, al};
  assign sum_b = {1'b0, bh} + {1'b0, bl};

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Select the operands of the shared multiplier for the current state.
  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      MUL_Z0: begin
        mx = {1'b0, al};
        my = {1'b0, bl};
      end
      MUL_Z2: begin
        mx = {1'b0, ah};
        my = {1'b0, bh};
      end
      MUL_Z1: begin
        mx = sum_a;
        my = sum_b;
      end
      default: begin
        mx = '0;
        my = '0;
      end
    endcase
  end

  karatsuba_core_mul #(.N(MW)) u_core (
    .x    (mx),
    .y    (my),
    .prod (mprod)
  );

  // Middle term: (ah+al)(bh+bl) - z2 - z0 = ah*bl + al*bh, never negative.
  assign z1_full = mprod - {2'b00, z2} - {2'b00, z0};

`ifdef KARATSUBA_APPROX_EN
  localparam logic [PW-1:0] ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] APX_MASK = (ONE_P << APPROX_BITS) - ONE_P;

  // Approximate assembly: low z0 bits dropped and low product bits forced to zero.
  always_comb begin
    z0_term = {{WIDTH{1'b0}}, z0} & ~APX_MASK;
    p_asm   = ({z2, {WIDTH{1'b0}}}
               + ({{(PW-WIDTH-2){1'b0}}, z1} << H)
               + z0_term) & ~APX_MASK;
  end
`else
  // Exact assembly of the full 2*WIDTH-bit product.
  always_comb begin
    z0_term = {{WIDTH{1'b0}}, z0};
    p_asm   = {z2, {WIDTH{1'b0}}}
              + ({{(PW-WIDTH-2){1'b0}}, z1} << H)
              + z0_term;
  end
`endif

  // Next-state logic: one state per cycle through the multiply phases.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MUL_Z0;
      MUL_Z0:  state_nx = MUL_Z2;
      MUL_Z2:  state_nx = MUL_Z1;
      MUL_Z1:  state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? MUL_Z0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture and partial-product registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      z0  <= '0;
      z2  <= '0;
      z1  <= '0;
    end else begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
      end
      case (state)
        MUL_Z0:  z0 <= mprod[WIDTH-1:0];
        MUL_Z2:  z2 <= mprod[WIDTH-1:0];
        MUL_Z1:  z1 <= z1_full;
        default: ;
      endcase
    end
  end

  // Result register: load p once per operation in DONE, hold while stalled,
  // drop out_valid when the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= '0;
      out_valid <= 1'b0;
      loaded    <= 1'b0;
    end else if (state == DONE) begin
      if (!loaded) begin
        if (!out_valid || out_ready) begin
          p         <= p_asm;
          out_valid <= 1'b1;
          loaded    <= !out_ready;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        loaded    <= 1'b0;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Directed bench for karatsuba_seq_mult (WIDTH=32 main instance, WIDTH=16
// second instance). Expected values are hand-computed constants; with
// KARATSUBA_APPROX_EN defined the low 8 bits of each expectation are cleared.
module tb_karatsuba_seq_mult;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] p;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks;
  int errors;
  logic [63:0] exp_q[$];

  karatsuba_seq_mult #(.WIDTH(32), .APPROX_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  karatsuba_seq_mult #(.WIDTH(16), .APPROX_BITS(8)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .p(p16), .busy(busy16)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ex64(input logic [63:0] v);
`ifdef KARATSUBA_APPROX_EN
    ex64 = v & ~64'hFF;
`else
    ex64 = v;
`endif
  endfunction

  function automatic logic [31:0] ex32(input logic [31:0] v);
`ifdef KARATSUBA_APPROX_EN
    ex32 = v & ~32'hFF;
`else
    ex32 = v;
`endif
  endfunction

  // Driver: offer one pair, then count edges until out_valid (bounded).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL run_op_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = p;
  endtask

  task automatic run_op16(input logic [15:0] x, input logic [15:0] y,
                          output logic [31:0] res, output int lat);
    in_valid16 = 1'b1; a16 = x; b16 = y;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = p16;
  endtask

  // Let any presented result be taken and the block return to IDLE.
  task automatic drain;
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((out_valid || busy) && g < 20) begin
      @(posedge clk); #1; g++;
    end
    checks++;
    if (out_valid || busy) begin
      errors++;
      $display("FAIL drain: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p !== 64'h0)     begin errors++; $display("FAIL reset_p: got %h required 0", p); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (p16 !== 32'h0)   begin errors++; $display("FAIL reset_p16: got %h required 0", p16); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready16: got %b required 1", in_ready16); end
  endtask

  task automatic test_basic;
    logic [63:0] r; int lat;
    out_ready = 1'b1;
    run_op(32'h0001_0000, 32'h0000_00C7, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d required 4", lat); end
    checks++; if (r !== ex64(64'h0000_0000_00C7_0000)) begin errors++; $display("FAIL basic_p: got %h required %h", r, ex64(64'h0000_0000_00C7_0000)); end
    drain();
  endtask

  task automatic test_carry;
    logic [63:0] r; int lat;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency: got %0d required 4", lat); end
    checks++; if (r !== ex64(64'hFFFF_FFFE_0000_0001)) begin errors++; $display("FAIL carry_p: got %h required %h", r, ex64(64'hFFFF_FFFE_0000_0001)); end
    drain();
  endtask

  task automatic test_vectors;
    logic [63:0] r; int lat;
    run_op(32'h0001_0001, 32'h0001_0001, r, lat);
    checks++; if (r !== ex64(64'h0000_0001_0002_0001)) begin errors++; $display("FAIL vec_mid_p: got %h required %h", r, ex64(64'h0000_0001_0002_0001)); end
    drain();
    run_op(32'h8000_0000, 32'h0000_0002, r, lat);
    checks++; if (r !== ex64(64'h0000_0001_0000_0000)) begin errors++; $display("FAIL vec_msb_p: got %h required %h", r, ex64(64'h0000_0001_0000_0000)); end
    drain();
  endtask

  task automatic test_stall;
    logic [63:0] r; int lat;
    out_ready = 1'b0;
    run_op(32'h0000_0100, 32'h0000_0300, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency: got %0d required 4", lat); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      checks++; if (p !== ex64(64'h0003_0000)) begin errors++; $display("FAIL stall_p[%0d]: got %h required %h", i, p, ex64(64'h0003_0000)); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %b required 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready[%0d]: got %b required 0", i, in_ready); end
      checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL stall_busy[%0d]: got %b required 1", i, busy); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_taken_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL stall_taken_busy: got %b required 0", busy); end
  endtask

  // Scoreboard-driven back-to-back run with in_valid and out_ready held high.
  task automatic test_back_to_back;
    logic [31:0] xs[3];
    logic [31:0] ys[3];
    int res_edge[3];
    int acc_idx, got, edge_n, first_acc;
    logic rdy;
    logic [63:0] exp_v;
    xs = '{32'd2, 32'd5, 32'hFFFF_FFFF};
    ys = '{32'd3, 32'd7, 32'd1};
    exp_q.delete();
    exp_q.push_back(ex64(64'd6));
    exp_q.push_back(ex64(64'd35));
    exp_q.push_back(ex64(64'h0000_0000_FFFF_FFFF));
    out_ready = 1'b1;
    acc_idx = 0; got = 0; edge_n = 0; first_acc = 0;
    in_valid = 1'b1; a = xs[0]; b = ys[0];
    while (got < 3 && edge_n < 60) begin
      rdy = in_ready && in_valid;
      @(posedge clk); #1; edge_n++;
      if (rdy) begin
        if (acc_idx == 0) first_acc = edge_n;
        acc_idx++;
        if (acc_idx < 3) begin a = xs[acc_idx]; b = ys[acc_idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        res_edge[got] = edge_n;
        exp_v = exp_q.pop_front();
        checks++;
        if (p !== exp_v) begin errors++; $display("FAIL b2b_p[%0d]: got %h required %h", got, p, exp_v); end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d results required 3", got);
    end else begin
      checks++; if (res_edge[0] - first_acc !== 4) begin errors++; $display("FAIL b2b_latency: got %0d required 4", res_edge[0] - first_acc); end
      checks++; if (res_edge[1] - res_edge[0] !== 4) begin errors++; $display("FAIL b2b_gap1: got %0d required 4", res_edge[1] - res_edge[0]); end
      checks++; if (res_edge[2] - res_edge[1] !== 4) begin errors++; $display("FAIL b2b_gap2: got %0d required 4", res_edge[2] - res_edge[1]); end
    end
    drain();
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (p !== 64'h0)        begin errors++; $display("FAIL mid_rst_p: got %h required 0", p); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
    run_op(32'd3, 32'd4, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_next_latency: got %0d required 4", lat); end
    checks++; if (r !== ex64(64'd12)) begin errors++; $display("FAIL mid_next_p: got %h required %h", r, ex64(64'd12)); end
    drain();
  endtask

  task automatic test_width16;
    logic [31:0] r; int lat;
    out_ready16 = 1'b1;
    run_op16(16'hFFFF, 16'hFFFF, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL w16_latency: got %0d required 4", lat); end
    checks++; if (r !== ex32(32'hFFFE_0001)) begin errors++; $display("FAIL w16_max_p: got %h required %h", r, ex32(32'hFFFE_0001)); end
    repeat (2) @(posedge clk);
    #1;
    run_op16(16'h0000, 16'hABCD, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL w16_zero_p: got %h required 0", r); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
